// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
//  Shared types and sizing helpers for the GPU raster blocks.
//  Contents:
//    DEF_W_BITS / DEF_H_BITS  default screen coordinate widths
//    coord_x_t / coord_y_t    coordinate types at the default widths
//    line_state_t             line rasterizer FSM states
//    err_bits()               width of the signed Bresenham error/delta terms
// ---------------------------------------------------------------------------
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif

package gpu_pkg;

  localparam int DEF_W_BITS = `WIDTH_BITS;
  localparam int DEF_H_BITS = `HEIGHT_BITS;

  typedef logic [DEF_W_BITS-1:0] coord_x_t;
  typedef logic [DEF_H_BITS-1:0] coord_y_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } line_state_t;

  // The error term spans roughly [-|dy|, +|dx|] and is doubled during a
  // step, so one bit for sign plus one bit of headroom above the wider axis.
  function automatic int err_bits(input int w_bits, input int h_bits);
    return ((w_bits > h_bits) ? w_bits : h_bits) + 2;
  endfunction

endpackage

// File: rtl/gpu_line_step.sv
// ---------------------------------------------------------------------------
// gpu_line_step
//  Purely combinational single Bresenham step. Given the current error term,
//  the deltas (dx >= 0, dy <= 0), step directions and current point, returns
//  the next error term and point. Shared with the fill engine's edge walker.
//  Ports:
//    err_i, dx_i, dy_i   signed error and deltas
//    sx_neg_i, sy_neg_i  1 = step towards decreasing x / y
//    x_i, y_i            current point
//    err_o, x_o, y_o     next error term and point
// ---------------------------------------------------------------------------
module gpu_line_step
  import gpu_pkg::*;
#(
  parameter int W_BITS   = DEF_W_BITS,
  parameter int H_BITS   = DEF_H_BITS,
  parameter int ERR_BITS = err_bits(DEF_W_BITS, DEF_H_BITS)
) (
  input  logic signed [ERR_BITS-1:0] err_i,
  input  logic signed [ERR_BITS-1:0] dx_i,
  input  logic signed [ERR_BITS-1:0] dy_i,
  input  logic                       sx_neg_i,
  input  logic                       sy_neg_i,
  input  logic        [W_BITS-1:0]   x_i,
  input  logic        [H_BITS-1:0]   y_i,
  output logic signed [ERR_BITS-1:0] err_o,
  output logic        [W_BITS-1:0]   x_o,
  output logic        [H_BITS-1:0]   y_o
);

  logic signed [ERR_BITS:0] e2;
  logic signed [ERR_BITS:0] dx_ext;
  logic signed [ERR_BITS:0] dy_ext;
  logic                     step_x;
  logic                     step_y;

  // Both axis decisions look at the pre-step error; the two corrections are
  // summed so a diagonal move is a single update. e2 gets one extra bit so
  // doubling never overflows.
  always_comb begin
    e2     = {err_i, 1'b0};
    dx_ext = {dx_i[ERR_BITS-1], dx_i};
    dy_ext = {dy_i[ERR_BITS-1], dy_i};
    step_x = (e2 >= dy_ext);
    step_y = (e2 <= dx_ext);

    err_o = err_i;
    x_o   = x_i;
    y_o   = y_i;
    if (step_x) begin
      err_o = err_o + dy_i;
      x_o   = sx_neg_i ? (x_i - W_BITS'(1)) : (x_i + W_BITS'(1));
    end
    if (step_y) begin
      err_o = err_o + dx_i;
      y_o   = sy_neg_i ? (y_i - H_BITS'(1)) : (y_i + H_BITS'(1));
    end
  end

endmodule

// File: rtl/gpu_line_rasterizer.sv
// ---------------------------------------------------------------------------
// gpu_line_rasterizer
//  Bresenham line rasterizer. Accepts one segment (x0,y0)->(x1,y1) and offers
//  one pixel per cycle to the output decoder, advancing only when the
//  framebuffer writer accepts it (pixel_ready).
//  Ports:
//    clk, rst             clock, asynchronous active-high reset
//    start                begin a new line (honoured only when idle)
//    abort                cancel the line in progress
//    x0_i, y0_i           start point
//    x1_i, y1_i           end point
//    pixel_ready          downstream accepts the offered pixel this cycle
//    x_line_o, y_line_o   offered pixel (registered)
//    line_active          pixel on x/y_line_o is valid
//    busy                 line being set up or drawn
//    done                 one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------
module gpu_line_rasterizer
  import gpu_pkg::*;
#(
  parameter int W_BITS = DEF_W_BITS,
  parameter int H_BITS = DEF_H_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [W_BITS-1:0] x0_i,
  input  logic [W_BITS-1:0] x1_i,
  input  logic [H_BITS-1:0] y0_i,
  input  logic [H_BITS-1:0] y1_i,
  input  logic              pixel_ready,
  output logic [W_BITS-1:0] x_line_o,
  output logic [H_BITS-1:0] y_line_o,
  output logic              line_active,
  output logic              busy,
  output logic              done
);

  localparam int ERR_BITS = err_bits(W_BITS, H_BITS);

  line_state_t state_q, state_d;

  logic        [W_BITS-1:0]   x0_q, x0_d, x1_q, x1_d;
  logic        [H_BITS-1:0]   y0_q, y0_d, y1_q, y1_d;
  logic signed [ERR_BITS-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                       sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic        [W_BITS-1:0]   x_q, x_d;
  logic        [H_BITS-1:0]   y_q, y_d;
  logic                       line_active_q, line_active_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic        [W_BITS-1:0]   x_span;
  logic        [H_BITS-1:0]   y_span;
  logic signed [ERR_BITS-1:0] setup_dx, setup_dy;
  logic                       last_pixel;
  logic signed [ERR_BITS-1:0] step_err;
  logic        [W_BITS-1:0]   step_x;
  logic        [H_BITS-1:0]   step_y;

  gpu_line_step #(
    .W_BITS   (W_BITS),
    .H_BITS   (H_BITS),
    .ERR_BITS (ERR_BITS)
  ) u_step (
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .err_o    (step_err),
    .x_o      (step_x),
    .y_o      (step_y)
  );

  // Spans are taken as unsigned magnitudes first and then zero-extended, so
  // full-width coordinates never produce a spurious negative delta.
  always_comb begin
    x_span     = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    y_span     = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    setup_dx   = $signed(ERR_BITS'(x_span));
    setup_dy   = -$signed(ERR_BITS'(y_span));
    last_pixel = (x_q == x1_q) && (y_q == y1_q);
  end

  // Abort takes priority over acceptance of the current pixel. Status
  // outputs are derived from the next state so they are registered yet
  // line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    x_d      = x_q;
    y_d      = y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = x0_i;
          y0_d    = y0_i;
          x1_d    = x1_i;
          y1_d    = y1_i;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dx_d     = setup_dx;
          dy_d     = setup_dy;
          err_d    = setup_dx + setup_dy;
          sx_neg_d = !(x0_q < x1_q);
          sy_neg_d = !(y0_q < y1_q);
          x_d      = x0_q;
          y_d      = y0_q;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pixel_ready) begin
          if (last_pixel) begin
            state_d = DONE;
          end else begin
            err_d = step_err;
            x_d   = step_x;
            y_d   = step_y;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    line_active_d = (state_d == DRAW);
    busy_d        = (state_d == SETUP) || (state_d == DRAW);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      err_q         <= '0;
      sx_neg_q      <= 1'b0;
      sy_neg_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_active_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      err_q         <= err_d;
      sx_neg_q      <= sx_neg_d;
      sy_neg_q      <= sy_neg_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_active_q <= line_active_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign x_line_o    = x_q;
  assign y_line_o    = y_q;
  assign line_active = line_active_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_gpu_line_rasterizer.sv
// ---------------------------------------------------------------------------
// tb_gpu_line_rasterizer
//  Directed bench for gpu_line_rasterizer: horizontal line, steep reverse
//  line, backpressure, single point, ignored start, abort and async reset.
// ---------------------------------------------------------------------------
module tb_gpu_line_rasterizer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [9:0] x0_i, x1_i;
  logic [8:0] y0_i, y1_i;
  logic       pixel_ready;
  logic [9:0] x_line_o;
  logic [8:0] y_line_o;
  logic       line_active;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  gpu_line_rasterizer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .x0_i        (x0_i),
    .x1_i        (x1_i),
    .y0_i        (y0_i),
    .y1_i        (y1_i),
    .pixel_ready (pixel_ready),
    .x_line_o    (x_line_o),
    .y_line_o    (y_line_o),
    .line_active (line_active),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a segment with a one-cycle start pulse; returns one cycle later
  // with the DUT in SETUP.
  task automatic drive_start(input logic [9:0] ax0, input logic [8:0] ay0,
                             input logic [9:0] ax1, input logic [8:0] ay1);
    x0_i  = ax0;
    y0_i  = ay0;
    x1_i  = ax1;
    y1_i  = ay1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++;
    if ({x_line_o, y_line_o, line_active, busy, done} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got x=%0d y=%0d act=%b busy=%b done=%b, want all 0",
               x_line_o, y_line_o, line_active, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_horizontal();
    int ex[4] = '{0, 1, 2, 3};
    pixel_ready = 1'b1;
    drive_start(10'd0, 9'd0, 10'd3, 9'd0);
    vectors++;
    if ({busy, line_active} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL horiz_setup: got busy=%b act=%b, want busy=1 act=0", busy, line_active);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'(ex[i]), 9'd0}) begin
        miscompares++;
        $display("[TB] FAIL horiz_pix%0d: got act=%b (%0d,%0d), want act=1 (%0d,0)",
                 i, line_active, x_line_o, y_line_o, ex[i]);
      end
      tick();
    end
    vectors++;
    if ({done, line_active, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL horiz_done: got done=%b act=%b busy=%b, want 1 0 0", done, line_active, busy);
    end
    // A start presented while in DONE must be dropped.
    drive_start(10'd5, 9'd5, 10'd6, 9'd6);
    vectors++;
    if ({done, busy, line_active} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL start_in_done: got done=%b busy=%b act=%b, want 0 0 0", done, busy, line_active);
    end
    tick();
  endtask

  task automatic test_steep_reverse();
    int ex[6] = '{2, 2, 1, 1, 0, 0};
    int ey[6] = '{5, 4, 3, 2, 1, 0};
    pixel_ready = 1'b1;
    drive_start(10'd2, 9'd5, 10'd0, 9'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'(ex[i]), 9'(ey[i])}) begin
        miscompares++;
        $display("[TB] FAIL steep_pix%0d: got act=%b (%0d,%0d), want act=1 (%0d,%0d)",
                 i, line_active, x_line_o, y_line_o, ex[i], ey[i]);
      end
      tick();
    end
    vectors++;
    if ({done, line_active} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL steep_done: got done=%b act=%b, want 1 0", done, line_active);
    end
    tick();
  endtask

  task automatic test_backpressure();
    pixel_ready = 1'b1;
    drive_start(10'd0, 9'd0, 10'd2, 9'd2);
    tick();
    vectors++;
    if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'd0, 9'd0}) begin
      miscompares++;
      $display("[TB] FAIL bp_pix0: got act=%b (%0d,%0d), want act=1 (0,0)", line_active, x_line_o, y_line_o);
    end
    tick();
    pixel_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pixel_ready = 1'b1;
      vectors++;
      if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'd1, 9'd1}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d: got act=%b (%0d,%0d), want act=1 (1,1)",
                 i, line_active, x_line_o, y_line_o);
      end
      tick();
    end
    vectors++;
    if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'd2, 9'd2}) begin
      miscompares++;
      $display("[TB] FAIL bp_pix2: got act=%b (%0d,%0d), want act=1 (2,2)", line_active, x_line_o, y_line_o);
    end
    tick();
    vectors++;
    if ({done, line_active} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL bp_done: got done=%b act=%b, want 1 0", done, line_active);
    end
    tick();
  endtask

  task automatic test_single_point();
    pixel_ready = 1'b1;
    // start and abort together while idle: start must win.
    abort = 1'b1;
    drive_start(10'd7, 9'd7, 10'd7, 9'd7);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_with_abort: got busy=%b, want 1", busy);
    end
    tick();
    vectors++;
    if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'd7, 9'd7}) begin
      miscompares++;
      $display("[TB] FAIL point_pix: got act=%b (%0d,%0d), want act=1 (7,7)", line_active, x_line_o, y_line_o);
    end
    tick();
    vectors++;
    if ({done, line_active} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL point_done: got done=%b act=%b, want 1 0", done, line_active);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    pixel_ready = 1'b1;
    drive_start(10'd0, 9'd0, 10'd9, 9'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        x0_i  = 10'd4;
        y0_i  = 9'd4;
        x1_i  = 10'd5;
        y1_i  = 9'd5;
        start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      vectors++;
      if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'(i), 9'd0}) begin
        miscompares++;
        $display("[TB] FAIL busy_start_pix%0d: got act=%b (%0d,%0d), want act=1 (%0d,0)",
                 i, line_active, x_line_o, y_line_o, i);
      end
      tick();
    end
    vectors++;
    if ({done, line_active} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL busy_start_done: got done=%b act=%b, want 1 0", done, line_active);
    end
    tick();
  endtask

  task automatic test_abort();
    pixel_ready = 1'b1;
    drive_start(10'd0, 9'd0, 10'd9, 9'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'(i), 9'd0}) begin
        miscompares++;
        $display("[TB] FAIL abort_pix%0d: got act=%b (%0d,%0d), want act=1 (%0d,0)",
                 i, line_active, x_line_o, y_line_o, i);
      end
      if (i == 4) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    vectors++;
    if ({line_active, busy, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL abort_drop: got act=%b busy=%b done=%b, want 0 0 0", line_active, busy, done);
    end
    tick();
    vectors++;
    if ({line_active, busy, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL abort_no_done: got act=%b busy=%b done=%b, want 0 0 0", line_active, busy, done);
    end
  endtask

  task automatic test_async_reset();
    int ex[3] = '{1, 2, 3};
    int ey[3] = '{2, 3, 3};
    pixel_ready = 1'b1;
    drive_start(10'd0, 9'd0, 10'd9, 9'd0);
    tick();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({x_line_o, y_line_o, line_active, busy, done} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got x=%0d y=%0d act=%b busy=%b done=%b, want all 0",
               x_line_o, y_line_o, line_active, busy, done);
    end
    #1;
    rst = 1'b0;
    tick();
    drive_start(10'd1, 9'd2, 10'd3, 9'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({line_active, x_line_o, y_line_o} !== {1'b1, 10'(ex[i]), 9'(ey[i])}) begin
        miscompares++;
        $display("[TB] FAIL post_reset_pix%0d: got act=%b (%0d,%0d), want act=1 (%0d,%0d)",
                 i, line_active, x_line_o, y_line_o, ex[i], ey[i]);
      end
      tick();
    end
    vectors++;
    if ({done, line_active} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL post_reset_done: got done=%b act=%b, want 1 0", done, line_active);
    end
    tick();
  endtask

  // Scenarios run back to back; each leaves the DUT idle for the next.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    pixel_ready = 1'b0;
    x0_i        = '0;
    x1_i        = '0;
    y0_i        = '0;
    y1_i        = '0;
    test_reset();
    test_horizontal();
    test_steep_reverse();
    test_backpressure();
    test_single_point();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
